// File: rtl/uart_wishbone_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone bridge.
package uart_wishbone_bridge_pkg;
  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_READ  = 8'h02;
  localparam logic [31:0] ERR_WORD  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB_WRITE, S_WB_READ, S_RDATA
  } state_t;
endpackage

// File: rtl/uart_wishbone_bridge_if.sv
// Byte-stream and Wishbone classic signals of the bridge; master is the bridge side.
interface uart_wishbone_bridge_if #(parameter int ADDR_WIDTH = 30);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [31:0]           wb_dat_w;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_dat_r;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
    output rx_ready, tx_data, tx_valid, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
    input  rx_ready, tx_data, tx_valid, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel
  );
endinterface

// File: rtl/uart_bridge_timeout.sv
// Loadable down-counter; expired flags the enabled cycle in which the count sits at zero.
module uart_bridge_timeout #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);
endmodule

// File: rtl/uart_wishbone_bridge.sv
// Byte-framed command bridge: UART byte stream in, Wishbone classic single-word cycles out.
module uart_wishbone_bridge
  import uart_wishbone_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int RX_TIMEOUT = 100000,
  parameter int WB_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_wishbone_bridge_if.master bus
);
  localparam int TMAX = (RX_TIMEOUT > WB_TIMEOUT) ? RX_TIMEOUT : WB_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_t                state, next;
  logic [1:0]            bcnt;
  logic [7:0]            wcnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           sr;
  logic [31:0]           shift_in;
  logic                  is_wr;
  logic                  rx_fire, tx_fire, in_rx, in_wb, wb_done, last_word;
  logic                  tmo, tmo_load;
  logic [TW-1:0]         tmo_val;

  assign rx_fire   = bus.rx_valid && bus.rx_ready;
  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign in_rx     = state inside {S_LEN, S_ADDR, S_WDATA};
  assign in_wb     = state inside {S_WB_WRITE, S_WB_READ};
  assign wb_done   = bus.wb_ack || bus.wb_err || tmo;
  assign last_word = (wcnt == 8'd1);
  assign shift_in  = {sr[23:0], bus.rx_data};

  // One counter serves both timeouts: RX idle and bus wait never overlap in time.
  assign tmo_load = rx_fire || (next != state);
  assign tmo_val  = (next inside {S_WB_WRITE, S_WB_READ}) ? TW'(WB_TIMEOUT - 1)
                                                         : TW'(RX_TIMEOUT - 1);

  uart_bridge_timeout #(.W(TW)) u_tmo (
    .clk(clk), .rst_n(rst_n), .load(tmo_load), .load_val(tmo_val),
    .en(in_rx || in_wb), .expired(tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:     if (rx_fire && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) next = S_LEN;
      S_LEN:      if (rx_fire) next = S_ADDR; else if (tmo) next = S_IDLE;
      S_ADDR: begin
        if (rx_fire) begin
          if (bcnt == 2'd3) next = (wcnt == 8'd0) ? S_IDLE : (is_wr ? S_WDATA : S_WB_READ);
        end else if (tmo) next = S_IDLE;
      end
      S_WDATA: begin
        if (rx_fire) begin
          if (bcnt == 2'd3) next = S_WB_WRITE;
        end else if (tmo) next = S_IDLE;
      end
      S_WB_WRITE: if (wb_done) next = last_word ? S_IDLE : S_WDATA;
      S_WB_READ:  if (wb_done) next = S_RDATA;
      S_RDATA:    if (tx_fire && bcnt == 2'd3) next = last_word ? S_IDLE : S_WB_READ;
      default:    next = S_IDLE;
    endcase
  end

  // The same shift register assembles address/write words and serialises read words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      wcnt  <= '0;
      addr  <= '0;
      sr    <= '0;
      is_wr <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bcnt <= '0;
          if (rx_fire) is_wr <= (bus.rx_data == CMD_WRITE);
        end
        S_LEN: if (rx_fire) wcnt <= bus.rx_data;
        S_ADDR: if (rx_fire) begin
          sr   <= shift_in;
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) addr <= shift_in[ADDR_WIDTH-1:0];
        end
        S_WDATA: if (rx_fire) begin
          sr   <= shift_in;
          bcnt <= bcnt + 2'd1;
        end
        S_WB_WRITE: if (wb_done) begin
          addr <= addr + 1'b1;
          wcnt <= wcnt - 8'd1;
        end
        S_WB_READ: if (wb_done) begin
          sr   <= bus.wb_ack ? bus.wb_dat_r : ERR_WORD;
          addr <= addr + 1'b1;
        end
        S_RDATA: if (tx_fire) begin
          sr   <= {sr[23:0], 8'h00};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) wcnt <= wcnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = (state == S_IDLE) || in_rx;
  assign bus.tx_valid = (state == S_RDATA);
  assign bus.tx_data  = sr[31:24];
  assign bus.wb_cyc   = in_wb;
  assign bus.wb_stb   = in_wb;
  assign bus.wb_we    = (state == S_WB_WRITE);
  assign bus.wb_adr   = addr;
  assign bus.wb_dat_w = sr;
  assign bus.wb_sel   = 4'hF;
endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Scoreboard bench: frames are modelled into an expected event queue, a monitor pops on bus/tx activity.
module tb_uart_wishbone_bridge;
  import uart_wishbone_bridge_pkg::*;

  localparam int AW  = 30;
  localparam int RXT = 200;
  localparam int WBT = 32;

  typedef struct {
    int          kind;   // 0 bus write, 1 bus read, 2 tx byte
    logic [31:0] adr;
    logic [31:0] dat;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_wishbone_bridge_if #(.ADDR_WIDTH(AW)) bus();

  uart_wishbone_bridge #(.ADDR_WIDTH(AW), .RX_TIMEOUT(RXT), .WB_TIMEOUT(WBT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mode = 0;          // slave: 0 ack, 1 err, 2 silent
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;
  logic        force_stall = 1'b0;
  int          chk_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return fixed_en ? fixed_val : ((a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E);
  endfunction

  // Reference: what a complete frame must produce on the bus and tx side.
  task automatic model_frame(input logic [7:0] cmd, input int len, input logic [31:0] a,
                             input logic [31:0] wd[$]);
    logic [31:0] t, w;
    for (int i = 0; i < len; i++) begin
      t = (a + i) & ((32'd1 << AW) - 1);
      if (cmd == CMD_WRITE) exp_q.push_back('{0, t, wd[i]});
      else if (cmd == CMD_READ) begin
        exp_q.push_back('{1, t, 32'h0});
        w = (mode == 0) ? rd_fn(t) : 32'hFFFF_FFFF;
        for (int b = 3; b >= 0; b--) exp_q.push_back('{2, 32'h0, {24'h0, w[8*b +: 8]}});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n = 0;
    logic ok;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      @(negedge clk); ok = bus.rx_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 5000);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rx_accept: byte %h not taken within %0d cycles", b, n);
    end
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input logic [31:0] a,
                            input logic [31:0] wd[$], input int nbytes_w);
    send_byte(cmd);
    send_byte(len[7:0]);
    for (int k = 3; k >= 0; k--) send_byte(a[8*k +: 8]);
    for (int i = 0; i < nbytes_w; i++) send_byte(wd[i/4][8*(3 - i%4) +: 8]);
  endtask

  task automatic issue(input logic [7:0] cmd, input int len, input logic [31:0] a,
                       input logic [31:0] wd[$]);
    model_frame(cmd, len, a, wd);
    send_frame(cmd, len, a, wd, (cmd == CMD_WRITE) ? 4 * len : 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Wishbone slave with random wait states.
  initial begin
    int wait_cnt = 0;
    int cur_delay = 0;
    bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_r = '0;
    forever begin
      @(posedge clk); #1;
      bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
      if (rst_n && bus.wb_cyc && bus.wb_stb) begin
        if (wait_cnt >= cur_delay) begin
          if (mode == 0) begin bus.wb_ack = 1'b1; bus.wb_dat_r = rd_fn({2'b0, bus.wb_adr}); end
          else if (mode == 1) bus.wb_err = 1'b1;
          wait_cnt = 0; cur_delay = $urandom_range(0, 3);
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each bus cycle start and each tx transfer.
  logic       prev_cyc = 1'b0, prev_stall = 1'b0;
  logic [31:0] cyc_dat;
  logic [7:0] stall_dat;
  int         cyc_len = 0;
  ev_t        mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc = 1'b0; prev_stall = 1'b0;
    end else begin
      if (bus.wb_cyc && bus.wb_stb && !prev_cyc) begin
        cyc_dat = bus.wb_dat_w; cyc_len = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus: adr %h we %b", bus.wb_adr, bus.wb_we);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_kind", bus.wb_we ? 0 : 1, mon_e.kind);
          chk("wb_adr", {2'b0, bus.wb_adr}, mon_e.adr);
          if (bus.wb_we) chk("wb_dat_w", bus.wb_dat_w, mon_e.dat);
          chk("wb_sel", {28'h0, bus.wb_sel}, 32'hF);
        end
      end
      if (bus.wb_cyc) begin
        cyc_len++;
        if (bus.wb_we) chk("wb_dat_w_stable", bus.wb_dat_w, cyc_dat);
      end
      if (!bus.wb_cyc && prev_cyc && chk_len > 0) chk("wb_timeout_len", cyc_len, chk_len);
      prev_cyc = bus.wb_cyc;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: byte %h", bus.tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_kind", 2, mon_e.kind);
          chk("tx_data", {24'h0, bus.tx_data}, mon_e.dat);
        end
      end
      if (bus.tx_valid && !bus.tx_ready) begin
        if (prev_stall) chk("tx_hold", {24'h0, bus.tx_data}, {24'h0, stall_dat});
        stall_dat = bus.tx_data; prev_stall = 1'b1;
      end else prev_stall = 1'b0;
    end
  end

  initial begin
    #800_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd[$];
    logic [31:0] a;
    logic [7:0]  cmd;
    int          len, n;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_cyc", {31'h0, bus.wb_cyc}, 0);
    chk("rst_wb_stb", {31'h0, bus.wb_stb}, 0);
    chk("rst_wb_we", {31'h0, bus.wb_we}, 0);
    chk("rst_tx_valid", {31'h0, bus.tx_valid}, 0);
    chk("rst_rx_ready", {31'h0, bus.rx_ready}, 1);
    chk("rst_wb_adr", {2'b0, bus.wb_adr}, 0);
    chk("rst_wb_dat_w", bus.wb_dat_w, 0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: single write, single read with known data, wrapping burst.
    wd = '{32'h0000_000C};
    issue(CMD_WRITE, 1, 32'h0000_2403, wd);
    drain("drain_write");
    fixed_en = 1'b1; fixed_val = 32'hFACE_CA8C;
    issue(CMD_READ, 1, 32'h0400_0000, wd);
    drain("drain_read");
    fixed_en = 1'b0;
    wd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    issue(CMD_WRITE, 3, 32'h3FFF_FFFF, wd);
    drain("drain_wrap");

    // Silent slave: bus times out, read returns the error word.
    mode = 2; chk_len = WBT;
    issue(CMD_READ, 1, 32'h0000_0100, wd);
    drain("drain_wb_timeout");
    chk_len = 0;
    mode = 1;
    wd = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
    issue(CMD_WRITE, 2, 32'h0000_0200, wd);
    issue(CMD_READ, 2, 32'h0000_0300, wd);
    drain("drain_err");
    mode = 0;

    // Junk command, zero length, RX stall aborts.
    send_byte(8'h55);
    wd = '{};
    send_frame(CMD_WRITE, 0, 32'h0000_0400, wd, 0);
    send_frame(CMD_READ, 0, 32'h0000_0400, wd, 0);
    send_byte(CMD_WRITE); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    repeat (RXT + 20) @(posedge clk);
    #1;
    chk("rx_abort_idle", {31'h0, bus.rx_ready}, 1);
    issue(CMD_READ, 1, 32'h0000_0005, wd);
    drain("drain_rx_timeout");
    wd = '{32'hA5A5_0001, 32'hA5A5_0002};
    model_frame(CMD_WRITE, 1, 32'h0000_0600, wd);
    send_frame(CMD_WRITE, 2, 32'h0000_0600, wd, 6);
    repeat (RXT + 20) @(posedge clk);
    drain("drain_partial_burst");

    // Randomized frames.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 9);
      if (n == 0) begin
        cmd = 8'($urandom_range(3, 255));
        send_byte(cmd);
      end else begin
        cmd = (n < 5) ? CMD_WRITE : CMD_READ;
        len = $urandom_range(0, 3);
        a = $urandom;
        if (n == 3 || n == 7) a = 32'hFFFF_FFFE;
        wd = '{};
        for (int i = 0; i < len; i++) wd.push_back($urandom);
        issue(cmd, len, a, wd);
      end
    end
    drain("drain_random");

    // tx stall holds data, then reset mid bus cycle.
    force_stall = 1'b1;
    fixed_en = 1'b1; fixed_val = 32'h1234_5678;
    issue(CMD_READ, 1, 32'h0000_0700, wd);
    n = 0;
    while (!bus.tx_valid && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (50) @(posedge clk);
    #1;
    chk("tx_stall_valid", {31'h0, bus.tx_valid}, 1);
    chk("tx_stall_data", {24'h0, bus.tx_data}, 32'h12);
    force_stall = 1'b0;
    drain("drain_stall");
    fixed_en = 1'b0;
    mode = 2;
    issue(CMD_READ, 1, 32'h0000_0800, wd);
    n = 0;
    while (!bus.wb_cyc && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_wb_cyc", {31'h0, bus.wb_cyc}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_cyc", {31'h0, bus.wb_cyc}, 0);
    chk("mid_rst_wb_stb", {31'h0, bus.wb_stb}, 0);
    chk("mid_rst_rx_ready", {31'h0, bus.rx_ready}, 1);
    chk("mid_rst_tx_valid", {31'h0, bus.tx_valid}, 0);
    exp_q.delete();
    mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wd = '{32'hCAFE_0001};
    issue(CMD_WRITE, 1, 32'h0000_0900, wd);
    issue(CMD_READ, 1, 32'h0000_0901, wd);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
